// File: rtl/timed_memory_pkg.sv
// Shared definitions for the timed_memory slave: default depth, UART base address and FSM states.
package timed_memory_pkg;

    localparam int          memory_depth   = 12;
    localparam logic [31:0] uart_base_addr = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

endpackage

// File: rtl/timed_memory_memory_bank.sv
// Single-port 2**DEPTH x 32 synchronous RAM with byte write enables and a registered
// read-before-write output: rdata shows the word as it was before the same-cycle write.
module memory_bank
    import timed_memory_pkg::*;
#(
    parameter int DEPTH = memory_depth
) (
    input  logic             clk,
    input  logic             en,
    input  logic [DEPTH-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we[0]) mem[addr][7:0]   <= wdata[7:0];
            if (we[1]) mem[addr][15:8]  <= wdata[15:8];
            if (we[2]) mem[addr][23:16] <= wdata[23:16];
            if (we[3]) mem[addr][31:24] <= wdata[31:24];
        end
    end

endmodule

// File: rtl/timed_memory.sv
// Word-addressed valid/ready memory slave with configurable latency, UART byte port and tohost flags.
// Define TIMED_MEMORY_ERROR_EN to flag out-of-range accesses with memory_error instead of wrapping.
module timed_memory
    import timed_memory_pkg::*;
#(
    parameter int          DEPTH     = memory_depth,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] UART_ADDR = uart_base_addr,
    parameter int          HOST_WORD = 1024,
    parameter string       INIT_FILE = "memory.dat"
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error,
    output logic        uart_valid,
    output logic [7:0]  uart_data,
    output logic        test_done,
    output logic        test_pass
);

`ifdef TIMED_MEMORY_ERROR_EN
    localparam bit ERROR_EN = 1'b1;
`else
    localparam bit ERROR_EN = 1'b0;
`endif

    mem_state_t  state;
    logic [3:0]  counter;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        resp_zero_q;

    logic        accept;
    logic        go_resp;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_strb;
    logic        is_uart;
    logic        is_host;
    logic        out_of_range;
    logic        blocked;
    logic        bank_en;
    logic [31:0] bank_rdata;
    logic        unused_addr_bits;

    // With LATENCY=1 the request is committed on its accept edge, so decode must look at the live
    // inputs; otherwise the commit happens from BUSY using the latched copy.
    always_comb begin
        accept    = memory_valid && (state == IDLE || state == RESP);
        go_resp   = (LATENCY == 1) ? accept
                                   : (state == BUSY && counter == 4'(LATENCY - 1));
        cur_addr  = accept ? memory_addr  : addr_q;
        cur_wdata = accept ? memory_wdata : wdata_q;
        cur_strb  = (accept ? memory_instr : instr_q) ? 4'b0000
                                                       : (accept ? memory_wstrb : wstrb_q);
        is_uart      = (cur_addr[31:2] == UART_ADDR[31:2]);
        is_host      = (cur_addr[31:2] == 30'(HOST_WORD));
        out_of_range = (cur_addr[31:2] >= 30'(1 << DEPTH)) && !is_uart;
        blocked      = is_uart || (ERROR_EN && out_of_range);
        bank_en      = go_resp && !blocked && !rst;
    end

    assign unused_addr_bits = ^cur_addr[1:0];

    memory_bank #(
        .DEPTH(DEPTH)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .addr (cur_addr[DEPTH+1:2]),
        .we   (cur_strb),
        .wdata(cur_wdata),
        .rdata(bank_rdata)
    );

    assign memory_rdata = (memory_ready && !resp_zero_q) ? bank_rdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            instr_q      <= 1'b0;
            resp_zero_q  <= 1'b0;
            memory_ready <= 1'b0;
            memory_error <= 1'b0;
            uart_valid   <= 1'b0;
            uart_data    <= 8'h00;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
        end else begin
            memory_ready <= go_resp;
            memory_error <= go_resp && ERROR_EN && out_of_range;
            resp_zero_q  <= blocked;
            uart_valid   <= go_resp && is_uart && cur_strb[0];
            uart_data    <= (go_resp && is_uart && cur_strb[0]) ? cur_wdata[7:0] : 8'h00;

            // Only the first tohost write counts; later writes are stored but leave the flags alone.
            if (go_resp && is_host && !blocked && (|cur_strb) && !test_done) begin
                test_done <= 1'b1;
                test_pass <= (cur_wdata == 32'h1);
            end

            if (accept) begin
                addr_q  <= memory_addr;
                wdata_q <= memory_wdata;
                wstrb_q <= memory_wstrb;
                instr_q <= memory_instr;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= (LATENCY == 1) ? RESP : BUSY;
                        counter <= 4'd1;
                    end
                end
                BUSY: begin
                    if (go_resp) begin
                        state   <= RESP;
                        counter <= 4'd0;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                RESP: begin
                    if (accept) begin
                        state   <= (LATENCY == 1) ? RESP : BUSY;
                        counter <= 4'd1;
                    end else begin
                        state   <= IDLE;
                        counter <= 4'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timed_memory.sv
// Directed bench for timed_memory: a LATENCY=1 instance driven from a vector table plus a
// LATENCY=4 instance for the multi-cycle timing and reset-during-access sequences.
module tb_timed_memory;

`ifdef TIMED_MEMORY_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [31:0] UART = 32'h1000_0000;
    localparam logic [31:0] HOST = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        f_valid, f_instr;
    logic [31:0] f_addr, f_wdata, f_rdata;
    logic [3:0]  f_wstrb;
    logic        f_ready, f_error, f_uart_valid, f_done, f_pass;
    logic [7:0]  f_uart_data;

    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_ready, s_error, s_uart_valid, s_done, s_pass;
    logic [7:0]  s_uart_data;

    timed_memory #(.LATENCY(1)) u_fast (
        .rst(rst), .clk(clk),
        .memory_valid(f_valid), .memory_instr(f_instr), .memory_addr(f_addr),
        .memory_wdata(f_wdata), .memory_wstrb(f_wstrb), .memory_rdata(f_rdata),
        .memory_ready(f_ready), .memory_error(f_error),
        .uart_valid(f_uart_valid), .uart_data(f_uart_data),
        .test_done(f_done), .test_pass(f_pass)
    );

    timed_memory #(.LATENCY(4)) u_slow (
        .rst(rst), .clk(clk),
        .memory_valid(s_valid), .memory_instr(s_instr), .memory_addr(s_addr),
        .memory_wdata(s_wdata), .memory_wstrb(s_wstrb), .memory_rdata(s_rdata),
        .memory_ready(s_ready), .memory_error(s_error),
        .uart_valid(s_uart_valid), .uart_data(s_uart_data),
        .test_done(s_done), .test_pass(s_pass)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_uart;
        logic [7:0]  exp_uart_data;
        logic        exp_error;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int checks = 0;
    int fails  = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One-cycle request on the fast instance; returns at the negedge where its response is visible.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input logic instr);
        @(negedge clk);
        f_valid = 1'b1; f_addr = addr; f_wdata = wdata; f_wstrb = wstrb; f_instr = instr;
        @(negedge clk);
        f_valid = 1'b0; f_wstrb = 4'h0; f_instr = 1'b0;
    endtask

    // Request on the slow instance, then watch 8 cycles: optionally re-poke valid while busy and
    // optionally pulse reset at cycle rst_at.
    task automatic slow_access(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input bit poke, input int rst_at,
                               output int first, output int count, output logic [31:0] rdata);
        first = 0; count = 0; rdata = 32'h0;
        @(negedge clk);
        s_valid = 1'b1; s_addr = addr; s_wdata = wdata; s_wstrb = wstrb; s_instr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            s_valid = poke && (k == 1);
            if (k == rst_at) rst = 1'b1;
            if (k == rst_at + 1) rst = 1'b0;
            if (s_ready) begin
                count++;
                if (first == 0) begin
                    first = k;
                    rdata = s_rdata;
                end
            end
        end
        s_valid = 1'b0; s_wstrb = 4'h0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int first, count;
        logic [31:0] rd;

        vecs[0]  = '{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0};
        vecs[1]  = '{32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0};
        vecs[2]  = '{32'h0000_0040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{32'h0000_0080, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0};
        vecs[4]  = '{32'h0000_0080, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{32'h0000_0080, 32'h0,         4'h0, 1'b0, 1'b1, 32'h11BB_33DD, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h11BB_33DD, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{32'h0000_0080, 32'h0,         4'h0, 1'b0, 1'b1, 32'h11BB_33DD, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{UART,          32'h0000_0041, 4'h1, 1'b0, 1'b1, 32'h0,         1'b1, 8'h41, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{32'h0000_4000, 32'h1234_5678, 4'hF, 1'b0, 1'b1,
                     ERR_EN ? 32'h0 : 32'hCAFE_F00D, 1'b0, 8'h00, ERR_EN};
        vecs[11] = '{32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b1,
                     ERR_EN ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0, 8'h00, 1'b0};
        vecs[12] = '{32'h0000_4000, 32'h0,         4'h0, 1'b0, 1'b1,
                     ERR_EN ? 32'h0 : 32'h1234_5678, 1'b0, 8'h00, ERR_EN};

        rst = 1'b1;
        f_valid = 1'b0; f_instr = 1'b0; f_addr = 32'h0; f_wdata = 32'h0; f_wstrb = 4'h0;
        s_valid = 1'b0; s_instr = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; s_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        check_output("reset ready",      f_ready,      32'h0);
        check_output("reset rdata",      f_rdata,      32'h0);
        check_output("reset error",      f_error,      32'h0);
        check_output("reset uart_valid", f_uart_valid, 32'h0);
        check_output("reset uart_data",  f_uart_data,  32'h0);
        check_output("reset test_done",  f_done,       32'h0);
        check_output("reset test_pass",  f_pass,       32'h0);
        check_output("reset slow ready", s_ready,      32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr);
            check_output($sformatf("vec%0d ready", i), f_ready, 32'h1);
            if (vecs[i].chk_rdata)
                check_output($sformatf("vec%0d rdata", i), f_rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d uart_valid", i), f_uart_valid, vecs[i].exp_uart);
            check_output($sformatf("vec%0d uart_data", i), f_uart_data, vecs[i].exp_uart_data);
            check_output($sformatf("vec%0d error", i), f_error, vecs[i].exp_error);
            @(negedge clk);
            check_output($sformatf("vec%0d ready pulse ends", i), f_ready, 32'h0);
            check_output($sformatf("vec%0d uart pulse ends", i), f_uart_valid, 32'h0);
        end

        // Back-to-back requests at LATENCY=1: a response every cycle, write visible to the next read.
        @(negedge clk);
        f_valid = 1'b1; f_addr = 32'h100; f_wdata = 32'h1111_1111; f_wstrb = 4'hF;
        @(negedge clk);
        check_output("b2b first ready", f_ready, 32'h1);
        f_wstrb = 4'h0; f_wdata = 32'h0;
        @(negedge clk);
        check_output("b2b second ready", f_ready, 32'h1);
        check_output("b2b second rdata", f_rdata, 32'h1111_1111);
        f_valid = 1'b0;
        @(negedge clk);
        check_output("b2b idle ready", f_ready, 32'h0);

        // tohost: first write sets the sticky flags, a later write only updates memory.
        apply_stimulus(HOST, 32'h1, 4'hF, 1'b0);
        check_output("tohost done", f_done, 32'h1);
        check_output("tohost pass", f_pass, 32'h1);
        apply_stimulus(HOST, 32'h0, 4'hF, 1'b0);
        check_output("tohost rewrite rdata", f_rdata, 32'h1);
        check_output("tohost rewrite done", f_done, 32'h1);
        check_output("tohost rewrite pass", f_pass, 32'h1);
        apply_stimulus(HOST, 32'h0, 4'h0, 1'b0);
        check_output("tohost stored", f_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("tohost reset done", f_done, 32'h0);
        check_output("tohost reset pass", f_pass, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(HOST, 32'h2, 4'hF, 1'b0);
        check_output("tohost fail done", f_done, 32'h1);
        check_output("tohost fail pass", f_pass, 32'h0);

        // LATENCY=4: a single response exactly four cycles after valid; valid during BUSY is ignored.
        slow_access(32'h0, 32'h0, 4'h0, 1'b1, 0, first, count, rd);
        check_output("lat4 first ready cycle", first, 32'd4);
        check_output("lat4 ready count", count, 32'd1);

        // Reset while busy drops the request: no response and the write is never committed.
        slow_access(32'h8, 32'hAAAA_AAAA, 4'hF, 1'b0, 0, first, count, rd);
        check_output("lat4 preload ready cycle", first, 32'd4);
        slow_access(32'h8, 32'h5555_5555, 4'hF, 1'b0, 2, first, count, rd);
        check_output("rst in busy ready count", count, 32'd0);
        slow_access(32'h8, 32'h0, 4'h0, 1'b0, 0, first, count, rd);
        check_output("rst in busy readback cycle", first, 32'd4);
        check_output("rst in busy readback data", rd, 32'hAAAA_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
